// File: rtl/regfile_n.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports with optional write-through bypass, and an optional
// auto-incrementing program counter held in the top register.
module regfile_n #(
   parameter int unsigned WIDTH   = 9,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned BYPASS  = 1,
   parameter int unsigned PC_MODE = 1,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             pc_inc,
   output logic [WIDTH-1:0] pc_out,
   output logic [DEPTH-1:0] wr_valid
);

   localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;

   // Next-state: PC increment first, so a same-edge write to the top register overrides it.
   always_comb begin
      regs_d  = regs_q;
      valid_d = valid_q;
      if ((PC_MODE != 0) && pc_inc) begin
         regs_d[TOP] = regs_q[TOP] + WIDTH'(1);
      end
      if (wr_en) begin
         regs_d[wr_addr]  = wr_data;
         valid_d[wr_addr] = 1'b1;
      end
   end

   // State register: asynchronous clear, otherwise load next state.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= regs_d[i];
         end
         valid_q <= valid_d;
      end
   end

   // Read port A: forced to 0 in reset so a bypassed write cannot leak through.
   always_comb begin
      rd_data_a = '0;
      if (Reset) begin
         rd_data_a = regs_q[rd_addr_a];
         if ((BYPASS != 0) && wr_en && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
         end
      end
   end

   // Read port B: same rules as port A.
   always_comb begin
      rd_data_b = '0;
      if (Reset) begin
         rd_data_b = regs_q[rd_addr_b];
         if ((BYPASS != 0) && wr_en && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
         end
      end
   end

   // PC output always shows stored state, never bypassed.
   always_comb begin
      pc_out   = regs_q[TOP];
      wr_valid = valid_q;
   end

endmodule

// File: tb/tb_regfile_n.sv
// Self-checking bench for regfile_n: three instances share one stimulus
// (default, BYPASS=0, PC_MODE=0) and are checked against a behavioural model.
module tb_regfile_n;

   localparam int NI = 3;
   localparam int BYP [NI] = '{1, 0, 1};
   localparam int PCM [NI] = '{1, 1, 0};

   logic       clk = 1'b0;
   logic       Reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [8:0] wr_data = '0;
   logic [2:0] rd_addr_a = '0;
   logic [2:0] rd_addr_b = '0;
   logic       pc_inc = 1'b0;

   logic [8:0] rda [NI];
   logic [8:0] rdb [NI];
   logic [8:0] pco [NI];
   logic [7:0] wv  [NI];

   int checks = 0;
   int errors = 0;

   // Model state: plain integers per instance.
   int mem [NI][8];
   int mval [NI][8];

   always #5 clk = ~clk;

   regfile_n #(.WIDTH(9), .DEPTH(8), .BYPASS(1), .PC_MODE(1)) u_dut0 (
      .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]),
      .pc_inc(pc_inc), .pc_out(pco[0]), .wr_valid(wv[0]));
   regfile_n #(.WIDTH(9), .DEPTH(8), .BYPASS(0), .PC_MODE(1)) u_dut1 (
      .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]),
      .pc_inc(pc_inc), .pc_out(pco[1]), .wr_valid(wv[1]));
   regfile_n #(.WIDTH(9), .DEPTH(8), .BYPASS(1), .PC_MODE(0)) u_dut2 (
      .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]),
      .pc_inc(pc_inc), .pc_out(pco[2]), .wr_valid(wv[2]));

   task automatic chk(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d at %0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
      end
   endtask

   // Model of what a read port must return right now.
   function automatic int exp_rd(input int k, input int a);
      if (!Reset) return 0;
      if (BYP[k] != 0 && wr_en && a == int'(wr_addr)) return int'(wr_data);
      return mem[k][a];
   endfunction

   function automatic int exp_valid(input int k);
      int v = 0;
      for (int i = 0; i < 8; i++) if (mval[k][i] != 0) v += (1 << i);
      return v;
   endfunction

   // Model update: write wins over increment; increments wrap at 512.
   always @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int k = 0; k < NI; k++)
            for (int i = 0; i < 8; i++) begin
               mem[k][i]  <= 0;
               mval[k][i] <= 0;
            end
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (wr_en) begin
               mem[k][wr_addr]  <= int'(wr_data);
               mval[k][wr_addr] <= 1;
            end
            if (PCM[k] != 0 && pc_inc && !(wr_en && wr_addr == 3'd7))
               mem[k][7] <= (mem[k][7] + 1) % 512;
         end
      end
   end

   // Compare process: every output of every instance on each falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk("rd_data_a", k, int'(rda[k]), exp_rd(k, int'(rd_addr_a)));
         chk("rd_data_b", k, int'(rdb[k]), exp_rd(k, int'(rd_addr_b)));
         chk("pc_out", k, int'(pco[k]), mem[k][7]);
         chk("wr_valid", k, int'(wv[k]), exp_valid(k));
      end
   end

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("lit_rst_rd", 0, int'(rda[0]), 0);
      chk("lit_rst_pc", 0, int'(pco[0]), 0);
      chk("lit_rst_wv", 0, int'(wv[0]), 0);
      after_edge();
      Reset = 1'b1;

      // PC counts 0,1,2,3,4 with pc_inc held 4 cycles; PC_MODE=0 stays 0
      pc_inc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_pc_count", 0, int'(pco[0]), i);
         after_edge();
      end
      pc_inc = 1'b0;
      @(negedge clk);
      chk("lit_pc_count", 0, int'(pco[0]), 4);
      chk("lit_pc_off", 2, int'(pco[2]), 0);
      chk("lit_pc_nowv", 0, int'(wv[0]), 0);

      // Write 0x155 to address 2, read on both ports next cycle
      after_edge();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 9'h155; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
      after_edge();
      wr_en = 1'b0;
      @(negedge clk);
      chk("lit_wr_a", 1, int'(rda[1]), 'h155);
      chk("lit_wr_b", 1, int'(rdb[1]), int'(rda[1]));
      chk("lit_wr_wv", 0, int'(wv[0]), 'h04);

      // Bypass vs no bypass on port B
      after_edge();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 9'h0F0; rd_addr_b = 3'd5;
      @(negedge clk);
      chk("lit_byp_on", 0, int'(rdb[0]), 'h0F0);
      chk("lit_byp_off", 1, int'(rdb[1]), 'h000);
      after_edge();
      wr_en = 1'b0;
      @(negedge clk);
      chk("lit_byp_later", 1, int'(rdb[1]), 'h0F0);

      // Preload 0x1FF into PC and increment once: wraps to 0
      after_edge();
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 9'h1FF; rd_addr_a = 3'd7;
      after_edge();
      wr_en = 1'b0; pc_inc = 1'b1;
      @(negedge clk);
      chk("lit_pc_pre", 0, int'(pco[0]), 'h1FF);
      after_edge();
      pc_inc = 1'b0;
      @(negedge clk);
      chk("lit_pc_wrap", 0, int'(pco[0]), 'h000);
      chk("lit_pc_off_keep", 2, int'(pco[2]), 'h1FF);
      chk("lit_wv_mix", 0, int'(wv[0]), 'hA4);

      // Write and increment on the same edge: write wins
      after_edge();
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 9'h040; pc_inc = 1'b1;
      @(negedge clk);
      chk("lit_pc_nobyp", 0, int'(pco[0]), 'h000);
      after_edge();
      wr_en = 1'b0; pc_inc = 1'b0;
      @(negedge clk);
      chk("lit_wr_wins", 0, int'(pco[0]), 'h040);
      chk("lit_wv7", 0, int'(wv[0][7]), 1);
      chk("lit_ord7", 2, int'(rda[2]), 'h040);

      // Mixed directed vectors checked by the compare process
      for (int i = 0; i < 24; i++) begin
         after_edge();
         wr_en     = i[0];
         wr_addr   = 3'(i * 3);
         wr_data   = 9'(i * 37 + 5);
         rd_addr_a = 3'(i + 1);
         rd_addr_b = 3'(i * 3);
         pc_inc    = i[1] | i[2];
      end

      // Reg 3 holds 0x1A5, then reset asserted mid-cycle with a write in flight
      after_edge();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 9'h1A5; pc_inc = 1'b0;
      after_edge();
      wr_data = 9'h0AA; rd_addr_a = 3'd3; pc_inc = 1'b1;
      @(negedge clk);
      chk("lit_pre_rst", 1, int'(rda[1]), 'h1A5);
      #2;
      Reset = 1'b0;
      #1;
      chk("lit_async_rd", 0, int'(rda[0]), 0);
      chk("lit_async_rd", 1, int'(rda[1]), 0);
      chk("lit_async_wv", 0, int'(wv[0]), 0);
      chk("lit_async_pc", 0, int'(pco[0]), 0);
      repeat (2) @(negedge clk);
      chk("lit_hold_rd", 0, int'(rda[0]), 0);
      chk("lit_hold_wv", 0, int'(wv[0]), 0);
      after_edge();
      Reset = 1'b1; wr_en = 1'b0; pc_inc = 1'b0;
      @(negedge clk);
      chk("lit_post_rd", 1, int'(rda[1]), 0);
      chk("lit_post_wv", 0, int'(wv[0]), 0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
